// File: rtl/shake_msg_padder.sv
// Byte-stream front end for the SHAKE core: packs message bytes into RATE-bit
// blocks, applies SHAKE domain/0x80 padding and hands blocks over with valid/ready.
module shake_msg_padder #(
    parameter int         RATE   = 1344,
    parameter logic [7:0] DOMAIN = 8'h1F
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_valid,
    input  logic [7:0]      s_data,
    input  logic            s_empty,
    input  logic            s_last,
    output logic            s_ready,
    output logic            blk_valid,
    output logic [RATE-1:0] blk_data,
    output logic            blk_last,
    input  logic            blk_ready,
    output logic            busy
);
    // Handshake rule on both sides: a transfer happens on a rising clk edge where
    // valid && ready; the sender holds data/last stable while valid is high and
    // ready is low, and ready never depends combinationally on valid.

    localparam int RB = RATE / 8;
    localparam int CW = $clog2(RB);
    localparam logic [CW-1:0] LAST_IDX = CW'(RB - 1);
    localparam logic [CW-1:0] PEN_IDX  = CW'(RB - 2);

    typedef enum logic {
        FILL = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               state, state_next;
    logic [CW-1:0]        cnt;
    logic                 pad_pend;
    logic [RB-1:0][7:0]   blk_bytes;
    logic                 accept;
    logic                 handshake;

    assign blk_data = blk_bytes;
    assign busy     = (state != FILL) || (cnt != '0);

    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        blk_valid  = 1'b0;
        accept     = 1'b0;
        handshake  = 1'b0;
        case (state)
            FILL: begin
                s_ready = 1'b1;
                accept  = s_valid;
                if (s_valid && (s_last || (!s_empty && cnt == LAST_IDX)))
                    state_next = SEND;
            end
            SEND: begin
                blk_valid = 1'b1;
                handshake = blk_ready;
                if (blk_ready && !pad_pend)
                    state_next = FILL;
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FILL;
            cnt       <= '0;
            pad_pend  <= 1'b0;
            blk_bytes <= '0;
            blk_last  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                if (!s_empty) begin
                    blk_bytes[cnt] <= s_data;
                    if (!s_last) begin
                        if (cnt != LAST_IDX) cnt <= cnt + CW'(1);
                        else                 blk_last <= 1'b0;
                    end else if (cnt != LAST_IDX) begin
                        // Later assignment wins when DOMAIN itself lands in the final byte.
                        blk_bytes[cnt + CW'(1)] <= DOMAIN;
                        blk_bytes[RB-1] <= ((cnt == PEN_IDX) ? DOMAIN : 8'h00) | 8'h80;
                        blk_last <= 1'b1;
                    end else begin
                        // Message exactly filled the block: padding goes in an extra block.
                        blk_last <= 1'b0;
                        pad_pend <= 1'b1;
                    end
                end else if (s_last) begin
                    blk_bytes[cnt]  <= DOMAIN;
                    blk_bytes[RB-1] <= ((cnt == LAST_IDX) ? DOMAIN : 8'h00) | 8'h80;
                    blk_last        <= 1'b1;
                end
            end
            if (handshake) begin
                if (pad_pend) begin
                    blk_bytes       <= '0;
                    blk_bytes[0]    <= DOMAIN;
                    blk_bytes[RB-1] <= 8'h80;
                    pad_pend        <= 1'b0;
                    blk_last        <= 1'b1;
                end else begin
                    blk_bytes <= '0;
                    cnt       <= '0;
                    blk_last  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_shake_msg_padder.sv
// Directed bench for shake_msg_padder: empty/"abc"/boundary-length messages,
// extra pad block, output stall and mid-message reset.
module tb_shake_msg_padder;
    localparam int RATE = 1344;
    localparam int RB   = RATE / 8;

    logic            clk;
    logic            rst_n;
    logic            s_valid;
    logic [7:0]      s_data;
    logic            s_empty;
    logic            s_last;
    logic            s_ready;
    logic            blk_valid;
    logic [RATE-1:0] blk_data;
    logic            blk_last;
    logic            blk_ready;
    logic            busy;

    int total = 0;
    int bad   = 0;

    logic [RB-1:0][7:0] e;
    logic [RATE-1:0]    hold_data;

    shake_msg_padder #(.RATE(RATE), .DOMAIN(8'h1F)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_data(s_data), .s_empty(s_empty), .s_last(s_last),
        .s_ready(s_ready),
        .blk_valid(blk_valid), .blk_data(blk_data), .blk_last(blk_last),
        .blk_ready(blk_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input logic [RATE-1:0] obs, input logic [RATE-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one beat from a negedge and return 1 time unit after the accepting edge.
    task automatic send_beat(input logic [7:0] d, input logic empty, input logic last);
        int n;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_empty = empty;
        s_last  = last;
        n = 0;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk_bit("s_ready_timeout", s_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_seq(input int n, input logic last_on_final);
        for (int i = 0; i < n; i++)
            send_beat(8'(i), 1'b0, last_on_final && (i == n - 1));
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        s_valid = 1'b0;
        s_empty = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
    endtask

    // Wait (bounded) for a block, compare it, then complete one handshake.
    task automatic take_blk(input string tag, input logic [RATE-1:0] exp, input logic exp_last);
        int n;
        idle_inputs();
        n = 0;
        while (!blk_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk_bit({tag, "_valid"}, blk_valid, 1'b1);
        chk_blk({tag, "_data"}, blk_data, exp);
        chk_bit({tag, "_last"}, blk_last, exp_last);
        blk_ready = 1'b1;
        @(posedge clk);
        #1;
        blk_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_data    = 8'h00;
        s_empty   = 1'b0;
        s_last    = 1'b0;
        blk_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        chk_bit("rst_s_ready", s_ready, 1'b1);
        chk_bit("rst_blk_valid", blk_valid, 1'b0);
        chk_bit("rst_blk_last", blk_last, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_blk("rst_blk_data", blk_data, '0);

        // Empty message; blk_ready high in FILL must be ignored
        blk_ready = 1'b1;
        send_beat(8'hAA, 1'b1, 1'b1);
        blk_ready = 1'b0;
        chk_bit("empty_latency", blk_valid, 1'b1);
        chk_bit("empty_s_ready_send", s_ready, 1'b0);
        e = '0; e[0] = 8'h1F; e[RB-1] = 8'h80;
        take_blk("empty", e, 1'b1);
        chk_bit("empty_s_ready_after", s_ready, 1'b1);
        chk_bit("empty_busy_after", busy, 1'b0);
        chk_blk("empty_cleared", blk_data, '0);

        // "abc" with an empty non-last beat in the middle (must be a no-op)
        send_beat(8'h61, 1'b0, 1'b0);
        send_beat(8'h55, 1'b1, 1'b0);
        chk_bit("abc_busy_mid", busy, 1'b1);
        send_beat(8'h62, 1'b0, 1'b0);
        send_beat(8'h63, 1'b0, 1'b1);
        chk_bit("abc_latency", blk_valid, 1'b1);
        e = '0; e[0] = 8'h61; e[1] = 8'h62; e[2] = 8'h63; e[3] = 8'h1F; e[RB-1] = 8'h80;
        take_blk("abc", e, 1'b1);

        // 167 bytes: DOMAIN lands in the final byte -> 0x9F
        send_seq(167, 1'b1);
        e = '0;
        for (int i = 0; i < 167; i++) e[i] = 8'(i);
        e[RB-1] = 8'h9F;
        take_blk("len167", e, 1'b1);

        // 167 bytes then empty last beat -> final byte 0x9F as well
        send_seq(167, 1'b0);
        send_beat(8'h00, 1'b1, 1'b1);
        take_blk("len167_empty_last", e, 1'b1);

        // 168 bytes: full data block, then a pad-only block
        send_seq(168, 1'b1);
        e = '0;
        for (int i = 0; i < 168; i++) e[i] = 8'(i);
        take_blk("len168_blk1", e, 1'b0);
        chk_bit("len168_busy_pad", busy, 1'b1);
        chk_bit("len168_s_ready_pad", s_ready, 1'b0);
        e = '0; e[0] = 8'h1F; e[RB-1] = 8'h80;
        take_blk("len168_blk2", e, 1'b1);
        chk_bit("len168_s_ready_after", s_ready, 1'b1);

        // Stall: blk_ready low 20 cycles while the next message's first byte waits
        send_beat(8'h61, 1'b0, 1'b0);
        send_beat(8'h62, 1'b0, 1'b0);
        send_beat(8'h63, 1'b0, 1'b1);
        @(negedge clk);
        s_valid = 1'b1; s_data = 8'h64; s_empty = 1'b0; s_last = 1'b0;
        hold_data = blk_data;
        repeat (20) @(negedge clk);
        e = '0; e[0] = 8'h61; e[1] = 8'h62; e[2] = 8'h63; e[3] = 8'h1F; e[RB-1] = 8'h80;
        chk_blk("stall_data_stable", blk_data, hold_data);
        chk_blk("stall_data", blk_data, e);
        chk_bit("stall_last", blk_last, 1'b1);
        chk_bit("stall_valid", blk_valid, 1'b1);
        chk_bit("stall_s_ready", s_ready, 1'b0);
        blk_ready = 1'b1;
        @(posedge clk);
        #1;
        blk_ready = 1'b0;
        @(posedge clk);
        #1;
        chk_bit("stall_byte_taken_busy", busy, 1'b1);
        send_beat(8'h65, 1'b0, 1'b1);
        e = '0; e[0] = 8'h64; e[1] = 8'h65; e[2] = 8'h1F; e[RB-1] = 8'h80;
        take_blk("after_stall", e, 1'b1);

        // Reset after 50 bytes; the following "abc" must not see stale bytes
        send_seq(50, 1'b0);
        chk_bit("pre_reset_busy", busy, 1'b1);
        idle_inputs();
        do_reset();
        chk_bit("post_reset_busy", busy, 1'b0);
        chk_bit("post_reset_s_ready", s_ready, 1'b1);
        send_beat(8'h61, 1'b0, 1'b0);
        send_beat(8'h62, 1'b0, 1'b0);
        send_beat(8'h63, 1'b0, 1'b1);
        e = '0; e[0] = 8'h61; e[1] = 8'h62; e[2] = 8'h63; e[3] = 8'h1F; e[RB-1] = 8'h80;
        take_blk("abc_after_reset", e, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
